// File: rtl/setpoint_stepper.sv
// -----------------------------------------------------------------------------
// setpoint_stepper
//
// Turns the auto-repeat up/down pulse streams from the button pulse generator
// into a clamped, registered setpoint. Same-direction pulses that arrive close
// together form a run. The first AccelCount pulses of a run step by StepSmall
// and later pulses step by StepLarge. A run ends in three ways: a pause longer
// than MaxGap cycles, a reversal of direction, or a load.
//
// Ports
//   Clock       in   1      system clock, rising edge
//   nReset      in   1      synchronous active-low reset
//   iUp         in   1      up pulse stream (rising edges counted)
//   iDown       in   1      down pulse stream (rising edges counted)
//   iLoad       in   1      synchronous load strobe, beats pulses
//   iLoadValue  in   Width  value to load (clamped into range)
//   oValue      out  Width  current setpoint
//   oChanged    out  1      strobe in the first cycle a new value is shown
//   oAtMin      out  1      oValue == MinValue
//   oAtMax      out  1      oValue == MaxValue
//   oFast       out  1      large-step mode active
// -----------------------------------------------------------------------------
module setpoint_stepper #(
  parameter int ClockPeriod_ns = 20,
  parameter int GapInterval_ns = 300_000_000,
  parameter int Width          = 16,
  parameter int MinValue       = 0,
  parameter int MaxValue       = 1000,
  parameter int InitValue      = 0,
  parameter int StepSmall      = 1,
  parameter int StepLarge      = 10,
  parameter int AccelCount     = 8
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             iUp,
  input  logic             iDown,
  input  logic             iLoad,
  input  logic [Width-1:0] iLoadValue,
  output logic [Width-1:0] oValue,
  output logic             oChanged,
  output logic             oAtMin,
  output logic             oAtMax,
  output logic             oFast
);

  localparam int MaxGap = GapInterval_ns / ClockPeriod_ns;
  // The timer only ever holds 0 .. MaxGap-1; it restarts on timeout.
  localparam int GapW   = (MaxGap > 1) ? $clog2(MaxGap) : 1;
  localparam int RunW   = $clog2(AccelCount + 1);

  localparam logic [Width-1:0] MinV   = Width'(MinValue);
  localparam logic [Width-1:0] MaxV   = Width'(MaxValue);
  localparam logic [Width-1:0] InitV  = Width'(InitValue);
  localparam logic [Width-1:0] SmallV = Width'(StepSmall);
  localparam logic [Width-1:0] LargeV = Width'(StepLarge);
  localparam logic [RunW-1:0]  AccV   = RunW'(AccelCount);
  localparam logic [GapW-1:0]  GapEnd = GapW'(MaxGap - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOW = 2'd1,
    ST_FAST = 2'd2
  } state_t;

  // One extra bit of headroom, so the sum can never wrap past MaxValue.
  function automatic logic [Width-1:0] add_clamp(input logic [Width-1:0] v,
                                                 input logic [Width-1:0] s);
    logic [Width:0] sum;
    sum = {1'b0, v} + {1'b0, s};
    if (sum > {1'b0, MaxV}) return MaxV;
    return sum[Width-1:0];
  endfunction

  // The comparison is against MinValue + step, so v - s never underflows.
  function automatic logic [Width-1:0] sub_clamp(input logic [Width-1:0] v,
                                                 input logic [Width-1:0] s);
    logic [Width:0] lim;
    lim = {1'b0, MinV} + {1'b0, s};
    if ({1'b0, v} < lim) return MinV;
    return v - s;
  endfunction

  function automatic logic [Width-1:0] range_clamp(input logic [Width-1:0] v);
    if (v < MinV) return MinV;
    if (v > MaxV) return MaxV;
    return v;
  endfunction

  state_t           state_q, state_d;
  logic [Width-1:0] value_q, value_d;
  logic             changed_q, changed_d;
  logic [RunW-1:0]  run_q, run_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             dir_q, dir_d;      // 1 = up
  logic             up_hist_q, dn_hist_q;

  logic             up_edge, dn_edge, same_run;
  logic [Width-1:0] step;

  // State register (all sequential state).
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q   <= ST_IDLE;
      value_q   <= InitV;
      changed_q <= 1'b0;
      run_q     <= '0;
      gap_q     <= '0;
      dir_q     <= 1'b1;
      // Start high, so an input held through reset release is not an edge.
      up_hist_q <= 1'b1;
      dn_hist_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      changed_q <= changed_d;
      run_q     <= run_d;
      gap_q     <= gap_d;
      dir_q     <= dir_d;
      up_hist_q <= iUp;
      dn_hist_q <= iDown;
    end
  end

  // Next-state logic: load > pulse edges > gap timeout.
  always_comb begin
    up_edge  = iUp & ~up_hist_q;
    dn_edge  = iDown & ~dn_hist_q;
    same_run = (state_q != ST_IDLE) && (dir_q == up_edge);
    // Step size is decided from the state before this pulse is counted.
    step     = (state_q == ST_FAST && same_run) ? LargeV : SmallV;
    value_d  = value_q;
    run_d    = run_q;
    gap_d    = gap_q;
    dir_d    = dir_q;

    if (iLoad) begin
      value_d = range_clamp(iLoadValue);
      run_d   = '0;
      gap_d   = '0;
    end else if (up_edge && dn_edge) begin
      // Conflicting request: no step, just end the run.
      run_d = '0;
      gap_d = '0;
    end else if (up_edge || dn_edge) begin
      value_d = up_edge ? add_clamp(value_q, step) : sub_clamp(value_q, step);
      if (same_run) run_d = (run_q == AccV) ? run_q : run_q + RunW'(1);
      else          run_d = RunW'(1);
      dir_d = up_edge;
      gap_d = '0;
    end else if (state_q != ST_IDLE) begin
      if (gap_q == GapEnd) begin
        run_d = '0;
        gap_d = '0;
      end else begin
        gap_d = gap_q + GapW'(1);
      end
    end

    changed_d = (value_d != value_q);

    if (run_d == '0)       state_d = ST_IDLE;
    else if (run_d == AccV) state_d = ST_FAST;
    else                    state_d = ST_SLOW;
  end

  // Outputs.
  always_comb begin
    oValue   = value_q;
    oChanged = changed_q;
    oFast    = (state_q == ST_FAST);
    oAtMin   = (value_q == MinV);
    oAtMax   = (value_q == MaxV);
  end

endmodule

// File: tb/tb_setpoint_stepper.sv
// -----------------------------------------------------------------------------
// tb_setpoint_stepper
//
// Bench for setpoint_stepper with Min 0, Max 50, Init 5, steps 1/10,
// AccelCount 3 and MaxGap 10. Each driven cycle pushes the reference model's
// expected outputs onto a queue. The entry is popped and compared one clock
// later. The scenario tasks also check the key values as literal constants.
// -----------------------------------------------------------------------------
module tb_setpoint_stepper;

  localparam int W      = 16;
  localparam int MINV   = 0;
  localparam int MAXV   = 50;
  localparam int INITV  = 5;
  localparam int ACCEL  = 3;
  localparam int MAXGAP = 10;

  logic          Clock = 1'b0;
  logic          nReset;
  logic          iUp, iDown, iLoad;
  logic [W-1:0]  iLoadValue;
  logic [W-1:0]  oValue;
  logic          oChanged, oAtMin, oAtMax, oFast;

  setpoint_stepper #(
    .ClockPeriod_ns(20), .GapInterval_ns(200), .Width(W),
    .MinValue(MINV), .MaxValue(MAXV), .InitValue(INITV),
    .StepSmall(1), .StepLarge(10), .AccelCount(ACCEL)
  ) dut (
    .Clock(Clock), .nReset(nReset), .iUp(iUp), .iDown(iDown),
    .iLoad(iLoad), .iLoadValue(iLoadValue), .oValue(oValue),
    .oChanged(oChanged), .oAtMin(oAtMin), .oAtMax(oAtMax), .oFast(oFast)
  );

  always #10 Clock = ~Clock;

  typedef struct {
    int   val;
    logic chg, amin, amax, fast;
  } exp_t;

  exp_t sb_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  // Reference model state.
  int   m_val, m_run, m_since;
  logic m_dir, m_pu, m_pd, m_chg;

  task automatic chk_val(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst_n, input logic up, input logic dn,
                            input logic ld, input int lv);
    logic ue, de, cont;
    int   old, stp, nv;
    if (!rst_n) begin
      m_val = INITV; m_run = 0; m_since = 0; m_dir = 1'b1;
      m_pu = 1'b1; m_pd = 1'b1; m_chg = 1'b0;
      return;
    end
    ue = up & ~m_pu;
    de = dn & ~m_pd;
    m_pu = up;
    m_pd = dn;
    old  = m_val;
    if (ld) begin
      m_val = (lv > MAXV) ? MAXV : (lv < MINV) ? MINV : lv;
      m_run = 0;
    end else if (ue && de) begin
      m_run = 0;
    end else if (ue || de) begin
      cont = (m_run != 0) && (m_dir == ue);
      stp  = (cont && m_run == ACCEL) ? 10 : 1;
      nv   = ue ? m_val + stp : m_val - stp;
      m_val = (nv > MAXV) ? MAXV : (nv < MINV) ? MINV : nv;
      m_run = cont ? ((m_run + 1 > ACCEL) ? ACCEL : m_run + 1) : 1;
      m_dir = ue;
      m_since = 0;
    end else begin
      m_since++;
      if (m_since >= MAXGAP) m_run = 0;
    end
    m_chg = (m_val != old);
  endtask

  // One clock: drive inputs, push the expectation, then pop and compare.
  task automatic cyc(input logic rst_n, input logic up, input logic dn,
                     input logic ld = 1'b0, input int lv = 0);
    exp_t e;
    nReset = rst_n; iUp = up; iDown = dn; iLoad = ld; iLoadValue = W'(lv);
    model_step(rst_n, up, dn, ld, lv);
    e.val = m_val; e.chg = m_chg; e.fast = (m_run == ACCEL);
    e.amin = (m_val == MINV); e.amax = (m_val == MAXV);
    sb_q.push_back(e);
    @(posedge Clock);
    #1;
    if (sb_q.size() == 0) begin
      chk_val("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk_val("value",   int'(oValue), e.val);
      chk_val("changed", int'(oChanged), int'(e.chg));
      chk_val("fast",    int'(oFast), int'(e.fast));
      chk_val("atmin",   int'(oAtMin), int'(e.amin));
      chk_val("atmax",   int'(oAtMax), int'(e.amax));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  // One-cycle pulse, literal check of the result, then 4 quiet cycles.
  task automatic pulse(input logic up, input logic dn, input int ev, input int ec);
    cyc(1'b1, up, dn);
    chk_val("pulse_val", int'(oValue), ev);
    chk_val("pulse_chg", int'(oChanged), ec);
    idle(4);
  endtask

  initial begin
    // 1: reset with iUp held high, then hold it high after release.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    chk_val("rst_val", int'(oValue), 5);
    chk_val("rst_chg", int'(oChanged), 0);
    chk_val("rst_fast", int'(oFast), 0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
    chk_val("held_val", int'(oValue), 5);
    chk_val("held_chg", int'(oChanged), 0);
    cyc(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 6, 1);

    // 2: acceleration after the third pulse of the run.
    pulse(1'b1, 1'b0, 7, 1);
    pulse(1'b1, 1'b0, 8, 1);
    chk_val("fast_on", int'(oFast), 1);
    pulse(1'b1, 1'b0, 18, 1);
    pulse(1'b1, 1'b0, 28, 1);
    pulse(1'b1, 1'b0, 38, 1);

    // 3: clamp at the upper bound.
    pulse(1'b1, 1'b0, 48, 1);
    pulse(1'b1, 1'b0, 50, 1);
    chk_val("at_max", int'(oAtMax), 1);
    pulse(1'b1, 1'b0, 50, 0);

    // 4: reversal and gap timeout both restart the run.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 35);
    idle(2);
    pulse(1'b1, 1'b0, 36, 1);
    pulse(1'b1, 1'b0, 37, 1);
    pulse(1'b1, 1'b0, 38, 1);
    chk_val("fast_38", int'(oFast), 1);
    pulse(1'b0, 1'b1, 37, 1);
    chk_val("rev_fast", int'(oFast), 0);
    idle(12);
    pulse(1'b1, 1'b0, 38, 1);
    pulse(1'b1, 1'b0, 39, 1);
    pulse(1'b1, 1'b0, 40, 1);
    idle(12);
    chk_val("timeout_fast", int'(oFast), 0);
    pulse(1'b1, 1'b0, 41, 1);

    // 5: simultaneous edges, then load beats an edge.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 20);
    idle(2);
    pulse(1'b1, 1'b1, 20, 0);
    chk_val("simul_fast", int'(oFast), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 70);
    chk_val("load_val", int'(oValue), 50);
    chk_val("load_chg", int'(oChanged), 1);
    idle(4);
    chk_val("load_hold", int'(oValue), 50);

    // 6: clamp at the lower bound.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 2);
    idle(2);
    pulse(1'b0, 1'b1, 1, 1);
    pulse(1'b0, 1'b1, 0, 1);
    pulse(1'b0, 1'b1, 0, 0);
    chk_val("at_min", int'(oAtMin), 1);

    // A short random tail, compared against the model only.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0)
        cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
            int'($urandom_range(0, 70)));
      else
        cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
